id_pipe: RTL and testbench

ID_PIPE -- requirements
Module: id_pipe

---
 rtl/id_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_id_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe.sv
// Instruction-decode stage: RV32I decode, operand forwarding, load-use stall
// and a single registered output slot with valid/ready handshake.
module id_pipe #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             inst_i,
  input  logic [XLEN-1:0]         instaddr_i,
  output logic [4:0]              rs1_addr_o,
  output logic [4:0]              rs2_addr_o,
  output logic                    rs1_read_o,
  output logic                    rs2_read_o,
  input  logic [XLEN-1:0]         rs1_data_i,
  input  logic [XLEN-1:0]         rs2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wen_i,
  input  logic [5*NUM_FWD-1:0]    fwd_addr_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
  input  logic                    ex_is_load_i,
  input  logic [4:0]              ex_rd_i,
  input  logic                    flush_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             inst_o,
  output logic [XLEN-1:0]         instaddr_o,
  output logic [XLEN-1:0]         op1_o,
  output logic [XLEN-1:0]         op2_o,
  output logic [XLEN-1:0]         imm_o,
  output logic                    regs_wen_o,
  output logic [4:0]              rd_addr_o,
  output logic                    mem_ren_o,
  output logic                    mem_wen_o,
  output logic                    illegal_o
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            wen;
    logic            ren;
    logic            mwen;
    logic            ill;
  } pay_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            hazard, accept;
  pay_t            dec, pay_d, pay_q;
  logic            valid_d, valid_q;

  assign opcode     = inst_i[6:0];
  assign rd         = inst_i[11:7];
  assign funct3     = inst_i[14:12];
  assign rs1        = inst_i[19:15];
  assign rs2        = inst_i[24:20];
  assign rs1_addr_o = rs1;
  assign rs2_addr_o = rs2;

  assign imm_i = XLEN'($signed(inst_i[31:20]));
  assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));

  // Walk channels from highest index down so the lowest matching one wins.
  always_comb begin
    rs1_val = rs1_data_i;
    rs2_val = rs2_data_i;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_wen_i[i] && fwd_addr_i[5*i +: 5] == rs1) rs1_val = fwd_data_i[XLEN*i +: XLEN];
      if (fwd_wen_i[i] && fwd_addr_i[5*i +: 5] == rs2) rs2_val = fwd_data_i[XLEN*i +: XLEN];
    end
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  always_comb begin
    rs1_read_o = 1'b0;
    rs2_read_o = 1'b0;
    dec        = '0;
    dec.inst   = inst_i;
    dec.pc     = instaddr_i;
    case (opcode)
      OPC_OP_IMM: begin
        rs1_read_o = 1'b1;
        dec.op1    = rs1_val;
        dec.op2    = (funct3 == 3'b001 || funct3 == 3'b101) ? XLEN'(inst_i[24:20]) : imm_i;
        dec.imm    = imm_i;
        dec.wen    = 1'b1;
      end
      OPC_OP: begin
        rs1_read_o = 1'b1;
        rs2_read_o = 1'b1;
        dec.op1    = rs1_val;
        dec.op2    = rs2_val;
        dec.wen    = 1'b1;
      end
      OPC_LUI: begin
        dec.op1 = imm_u;
        dec.imm = imm_u;
        dec.wen = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1 = instaddr_i;
        dec.op2 = imm_u;
        dec.imm = imm_u;
        dec.wen = 1'b1;
      end
      OPC_JAL: begin
        dec.op1 = instaddr_i;
        dec.op2 = XLEN'(4);
        dec.imm = imm_j;
        dec.wen = 1'b1;
      end
      OPC_JALR: begin
        rs1_read_o = 1'b1;
        dec.op1    = instaddr_i;
        dec.op2    = XLEN'(4);
        dec.imm    = imm_i;
        dec.wen    = 1'b1;
      end
      OPC_BRANCH: begin
        rs1_read_o = 1'b1;
        rs2_read_o = 1'b1;
        dec.op1    = rs1_val;
        dec.op2    = rs2_val;
        dec.imm    = imm_b;
      end
      OPC_LOAD: begin
        rs1_read_o = 1'b1;
        dec.op1    = rs1_val;
        dec.imm    = imm_i;
        dec.wen    = 1'b1;
        dec.ren    = 1'b1;
      end
      OPC_STORE: begin
        rs1_read_o = 1'b1;
        rs2_read_o = 1'b1;
        dec.op1    = rs1_val;
        dec.op2    = rs2_val;
        dec.imm    = imm_s;
        dec.mwen   = 1'b1;
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.wen) dec.rd = rd;
  end

  assign hazard = in_valid & ex_is_load_i & (ex_rd_i != 5'd0) &
                  ((rs1_read_o & (rs1 == ex_rd_i)) | (rs2_read_o & (rs2 == ex_rd_i)));

  // During a flush the presented instruction is consumed and dropped.
  assign in_ready = !rst & (flush_i | ((!valid_q | out_ready) & !hazard));
  assign accept   = in_valid & in_ready & !flush_i;

  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      pay_d   = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
    end
  end

  assign out_valid  = valid_q;
  assign inst_o     = pay_q.inst;
  assign instaddr_o = pay_q.pc;
  assign op1_o      = pay_q.op1;
  assign op2_o      = pay_q.op2;
  assign imm_o      = pay_q.imm;
  assign regs_wen_o = pay_q.wen;
  assign rd_addr_o  = pay_q.rd;
  assign mem_ren_o  = pay_q.ren;
  assign mem_wen_o  = pay_q.mwen;
  assign illegal_o  = pay_q.ill;

endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: instruction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] inst_i, instaddr_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic        rs1_read_o, rs2_read_o;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [1:0]  fwd_wen_i;
  logic [9:0]  fwd_addr_i;
  logic [63:0] fwd_data_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_i;
  logic        flush_i;
  logic        out_valid, out_ready;
  logic [31:0] inst_o, instaddr_o, op1_o, op2_o, imm_o;
  logic        regs_wen_o, mem_ren_o, mem_wen_o, illegal_o;
  logic [4:0]  rd_addr_o;

  id_pipe #(.XLEN(32), .NUM_FWD(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_i(inst_i), .instaddr_i(instaddr_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_read_o(rs1_read_o), .rs2_read_o(rs2_read_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .fwd_wen_i(fwd_wen_i), .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
    .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .inst_o(inst_o), .instaddr_o(instaddr_o), .op1_o(op1_o), .op2_o(op2_o), .imm_o(imm_o),
    .regs_wen_o(regs_wen_o), .rd_addr_o(rd_addr_o), .mem_ren_o(mem_ren_o),
    .mem_wen_o(mem_wen_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADDI = 32'hFFF10093; // addi x1,x2,-1
  localparam logic [31:0] I_ADD  = 32'h001081B3; // add  x3,x1,x1
  localparam logic [31:0] I_SW   = 32'h0042A423; // sw   x4,8(x5)
  localparam logic [31:0] I_ILL  = 32'h0000007F;
  localparam logic [31:0] I_LUI  = 32'h123452B7; // lui  x5,0x12345
  localparam logic [31:0] I_AUI  = 32'h00001317; // auipc x6,1
  localparam logic [31:0] I_JAL  = 32'hFFDFF0EF; // jal  x1,-4
  localparam logic [31:0] I_JALR = 32'h00C08067; // jalr x0,12(x1)
  localparam logic [31:0] I_BEQ  = 32'hFE208CE3; // beq  x1,x2,-8
  localparam logic [31:0] I_LW   = 32'hFFC1A383; // lw   x7,-4(x3)
  localparam logic [31:0] I_SLLI = 32'h00309413; // slli x8,x1,3
  localparam logic [31:0] I_SRAI = 32'h4050D493; // srai x9,x1,5

  logic [31:0] rf [32];
  logic        fw_wen  [2];
  logic [4:0]  fw_addr [2];
  logic [31:0] fw_data [2];
  logic [31:0] itab [12];

  assign rs1_data_i = rf[inst_i[19:15]];
  assign rs2_data_i = rf[inst_i[24:20]];

  always_comb begin
    fwd_wen_i  = '0;
    fwd_addr_i = '0;
    fwd_data_i = '0;
    for (int i = 0; i < 2; i++) begin
      fwd_wen_i[i]         = fw_wen[i];
      fwd_addr_i[5*i +: 5] = fw_addr[i];
      fwd_data_i[32*i +: 32] = fw_data[i];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] inst, pc, op1, op2, imm;
    logic [4:0]  rd;
    logic        wen, ren, mwen, ill, op2_def, imm_def;
  } exp_t;

  exp_t m_pay;
  logic m_valid = 1'b0;
  logic m_known = 1'b0;
  logic started = 1'b0;

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    return v[bits-1] ? (v | (32'hFFFF_FFFF << bits)) : v;
  endfunction

  function automatic logic [31:0] src_val(input logic [4:0] s);
    if (s == 5'd0) return 32'd0;
    for (int i = 0; i < 2; i++)
      if (fw_wen[i] && fw_addr[i] == s) return fw_data[i];
    return rf[s];
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {7'h13, 7'h33, 7'h67, 7'h63, 7'h03, 7'h23};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h63, 7'h23};
  endfunction

  function automatic logic exp_ready();
    logic haz;
    haz = in_valid && ex_is_load_i && ex_rd_i != 0 &&
          ((uses_rs1(inst_i[6:0]) && inst_i[19:15] == ex_rd_i) ||
           (uses_rs2(inst_i[6:0]) && inst_i[24:20] == ex_rd_i));
    if (rst) return 1'b0;
    if (flush_i) return 1'b1;
    return (!m_valid || out_ready) && !haz;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [31:0] a, b, iimm, uimm;
    a = src_val(ins[19:15]);
    b = src_val(ins[24:20]);
    iimm = sext(32'(ins[31:20]), 12);
    uimm = {ins[31:12], 12'h000};
    e = '0;
    e.inst = ins; e.pc = pc; e.op2_def = 1'b1;
    case (ins[6:0])
      7'h13: begin
        e.op1 = a; e.wen = 1'b1;
        e.op2 = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? 32'(ins[24:20]) : iimm;
      end
      7'h33: begin e.op1 = a; e.op2 = b; e.wen = 1'b1; end
      7'h37: begin e.op1 = uimm; e.op2 = 0; e.wen = 1'b1; end
      7'h17: begin e.op1 = pc; e.op2 = uimm; e.wen = 1'b1; end
      7'h6F: begin
        e.op1 = pc; e.op2 = 4; e.wen = 1'b1; e.imm_def = 1'b1;
        e.imm = sext(32'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      end
      7'h67: begin e.op1 = pc; e.op2 = 4; e.wen = 1'b1; e.imm = iimm; e.imm_def = 1'b1; end
      7'h63: begin
        e.op1 = a; e.op2 = b; e.imm_def = 1'b1;
        e.imm = sext(32'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
      end
      7'h03: begin
        e.op1 = a; e.op2_def = 1'b0; e.imm = iimm; e.imm_def = 1'b1;
        e.ren = 1'b1; e.wen = 1'b1;
      end
      7'h23: begin
        e.op1 = a; e.op2 = b; e.mwen = 1'b1; e.imm_def = 1'b1;
        e.imm = sext(32'({ins[31:25], ins[11:7]}), 12);
      end
      default: begin e.ill = 1'b1; e.op1 = 0; e.op2 = 0; end
    endcase
    e.rd = e.wen ? ins[11:7] : 5'd0;
    return e;
  endfunction

  always @(posedge clk) begin
    logic r;
    r = exp_ready();
    if (rst) begin
      m_valid = 1'b0; m_pay = '0; m_pay.op2_def = 1'b1; m_pay.imm_def = 1'b1; m_known = 1'b1;
    end else if (flush_i) begin
      m_valid = 1'b0; m_known = 1'b0;
    end else if (in_valid && r) begin
      m_pay = model(inst_i, instaddr_i); m_valid = 1'b1; m_known = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, exp_ready());
      chk("rs1_addr", rs1_addr_o, inst_i[19:15]);
      chk("rs2_addr", rs2_addr_o, inst_i[24:20]);
      chk("rs1_read", rs1_read_o, uses_rs1(inst_i[6:0]));
      chk("rs2_read", rs2_read_o, uses_rs2(inst_i[6:0]));
      chk("out_valid", out_valid, m_valid);
      if (m_valid || m_known) begin
        chk("inst_o", inst_o, m_pay.inst);
        chk("instaddr_o", instaddr_o, m_pay.pc);
        chk("op1", op1_o, m_pay.op1);
        if (m_pay.op2_def) chk("op2", op2_o, m_pay.op2);
        if (m_pay.imm_def) chk("imm", imm_o, m_pay.imm);
        chk("rd_addr", rd_addr_o, m_pay.rd);
        chk("regs_wen", regs_wen_o, m_pay.wen);
        chk("mem_ren", mem_ren_o, m_pay.ren);
        chk("mem_wen", mem_wen_o, m_pay.mwen);
        chk("illegal", illegal_o, m_pay.ill);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; inst_i = ins; instaddr_i = pc;
  endtask

  task automatic set_fwd(input int ch, input logic w, input logic [4:0] a, input logic [31:0] d);
    fw_wen[ch] = w; fw_addr[ch] = a; fw_data[ch] = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hDEAD0000;
    rf[2] = 32'd5;
    itab = '{I_ADDI, I_ADD, I_SW, I_ILL, I_LUI, I_AUI, I_JAL, I_JALR, I_BEQ, I_LW, I_SLLI, I_SRAI};
    set_fwd(0, 0, 0, 0); set_fwd(1, 0, 0, 0);
    ex_is_load_i = 0; ex_rd_i = 0; flush_i = 0; out_ready = 1;
    rst = 1;
    present(I_ADDI, 32'h100);
    tick; tick;
    chk("lit_rst_in_ready", in_ready, 0);
    chk("lit_rst_valid", out_valid, 0);
    chk("lit_rst_op1", op1_o, 0);
    chk("lit_rst_wen", regs_wen_o, 0);

    rst = 0;
    tick;
    chk("lit_addi_valid", out_valid, 1);
    chk("lit_addi_op1", op1_o, 32'd5);
    chk("lit_addi_op2", op2_o, 32'hFFFF_FFFF);
    chk("lit_addi_rd", rd_addr_o, 1);
    chk("lit_addi_wen", regs_wen_o, 1);

    present(I_ADD, 32'h104);
    set_fwd(0, 1, 1, 32'hA); set_fwd(1, 1, 1, 32'hB);
    tick;
    chk("lit_fwd_op1", op1_o, 32'hA);
    chk("lit_fwd_op2", op2_o, 32'hA);
    set_fwd(0, 1, 0, 32'hA); set_fwd(1, 1, 0, 32'hB);
    tick;
    chk("lit_fwdx0_op1", op1_o, 32'h1001);
    chk("lit_fwdx0_op2", op2_o, 32'h1001);
    set_fwd(0, 0, 0, 0); set_fwd(1, 0, 0, 0);

    present(I_SW, 32'h10C);
    ex_is_load_i = 1; ex_rd_i = 4;
    #1;
    chk("lit_haz_in_ready", in_ready, 0);
    tick;
    chk("lit_bubble_valid", out_valid, 0);
    ex_is_load_i = 0;
    tick;
    chk("lit_sw_valid", out_valid, 1);
    chk("lit_sw_imm", imm_o, 32'd8);
    chk("lit_sw_mem_wen", mem_wen_o, 1);

    present(I_ILL, 32'h110);
    tick;
    chk("lit_ill", illegal_o, 1);
    chk("lit_ill_wen", regs_wen_o | mem_ren_o | mem_wen_o, 0);

    for (int i = 4; i < 12; i++) begin
      present(itab[i], 32'h200 + 4 * i);
      tick;
      chk("lit_stream_valid", out_valid, 1);
    end

    present(I_LW, 32'h300);
    tick;
    out_ready = 0;
    present(I_SLLI, 32'h304);
    repeat (3) begin
      tick;
      chk("lit_hold_valid", out_valid, 1);
      chk("lit_hold_inst", inst_o, I_LW);
      chk("lit_hold_in_ready", in_ready, 0);
    end
    flush_i = 1;
    #1;
    chk("lit_flush_in_ready", in_ready, 1);
    tick;
    flush_i = 0;
    chk("lit_flush_valid", out_valid, 0);

    out_ready = 1;
    present(I_SRAI, 32'h400);
    tick;
    chk("lit_srai_op2", op2_o, 32'd5);
    present(I_ADD, 32'h404);
    tick;
    rst = 1;
    present(I_ADDI, 32'h408);
    tick;
    rst = 0;
    chk("lit_mrst_valid", out_valid, 0);
    chk("lit_mrst_op1", op1_o, 0);
    chk("lit_mrst_op2", op2_o, 0);
    chk("lit_mrst_imm", imm_o, 0);
    chk("lit_mrst_inst", inst_o, 0);
    chk("lit_mrst_wen", regs_wen_o, 0);

    for (int c = 0; c < 80; c++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      inst_i       = itab[$urandom_range(0, 11)];
      instaddr_i   = 32'h800 + 4 * c;
      out_ready    = ($urandom_range(0, 2) != 0);
      flush_i      = ($urandom_range(0, 15) == 0);
      ex_is_load_i = $urandom_range(0, 1) != 0;
      ex_rd_i      = 5'($urandom_range(0, 7));
      for (int k = 0; k < 2; k++)
        set_fwd(k, $urandom_range(0, 1) != 0, 5'($urandom_range(0, 5)), $urandom);
      tick;
    end
    in_valid = 0; flush_i = 0; out_ready = 1; ex_is_load_i = 0;
    tick; tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
